button_io: RTL and testbench

Memory-mapped push-button peripheral for the miniRV SoC. It sits between the five board buttons and the Bridge's button read port. It synchronises and debounces each button, then exposes the debounced level plus sticky press/release event flags. Software clears the flags with write-1-to-clear, so it never misses a short press between polls.

---
 rtl/button_io.sv | 81 ++++++++
 tb/tb_button_io.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/button_io.sv
// Push-button peripheral: per-button two-flop synchroniser and debouncer, with the
// debounced level and sticky, write-1-to-clear press/release event flags.
module button_io #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  btn_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  localparam int unsigned NumBtn = 5;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NumBtn-1:0] s1_q, s2_q;
  logic [NumBtn-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [NumBtn];
  logic [CNT_W-1:0]  cnt_d [NumBtn];
  logic [NumBtn-1:0] press_q, press_d;
  logic [NumBtn-1:0] release_q, release_d;
  logic [NumBtn-1:0] clr_press, clr_release;
  logic              ev_write;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NumBtn; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign ev_write    = we_i & addr_i[2];
  assign clr_press   = ev_write ? data_i[4:0]  : '0;
  assign clr_release = ev_write ? data_i[12:8] : '0;

  // A new edge in the same cycle as a clear wins, so no event is lost.
  assign press_d   = (press_q & ~clr_press) | (stable_d & ~stable_q);
  assign release_d = (release_q & ~clr_release) | (~stable_d & stable_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    data_o = '0;
    if (addr_i[2]) begin
      data_o[4:0]  = press_q;
      data_o[12:8] = release_q;
    end else begin
      data_o[4:0]  = stable_q;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:3], addr_i[1:0], data_i[31:13], data_i[7:5]};

endmodule

// File: tb/tb_button_io.sv
// Directed bench for button_io with DEBOUNCE_CYCLES=4; inputs change 1 time unit
// after each rising edge and outputs are sampled there too.
module tb_button_io;

  localparam logic [31:0] AddrLevel  = 32'hFFFF_F078;
  localparam logic [31:0] AddrEvents = 32'hFFFF_F07C;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  button_io #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .btn_i (btn),
    .addr_i(addr),
    .we_i  (we),
    .data_i(wdata),
    .data_o(rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst   = 1'b1;
    btn   = '0;
    addr  = AddrLevel;
    we    = 1'b0;
    wdata = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    read_check("reset_level", AddrLevel, 32'h0);
    read_check("reset_events", AddrEvents, 32'h0);

    // Press button 0: level rises after edge 6
    btn = 5'b00001;
    for (int k = 1; k <= 5; k++) begin
      step();
      read_check($sformatf("press0_level_e%0d", k), AddrLevel, 32'h0);
    end
    step();
    read_check("press0_level_e6", AddrLevel, 32'h1);
    read_check("press0_events", AddrEvents, 32'h1);

    // 3-cycle glitch on button 2 is rejected
    btn = 5'b00101;
    step();
    step();
    step();
    btn = 5'b00001;
    for (int k = 0; k < 8; k++) step();
    read_check("glitch_level", AddrLevel, 32'h1);
    read_check("glitch_events", AddrEvents, 32'h1);
    check("glitch_cnt2", 32'(dut.cnt_q[2]), 32'h0);

    // Release button 0, then W1C
    btn = 5'b00000;
    for (int k = 0; k < 5; k++) step();
    read_check("release_level_e5", AddrLevel, 32'h1);
    step();
    read_check("release_level_e6", AddrLevel, 32'h0);
    read_check("release_events", AddrEvents, 32'h101);
    write(AddrEvents, 32'h1);
    read_check("w1c_press", AddrEvents, 32'h100);
    write(AddrEvents, 32'h100);
    read_check("w1c_release", AddrEvents, 32'h0);
    write(AddrEvents, 32'h0);
    read_check("w1c_zero", AddrEvents, 32'h0);

    // PRESS[3] set on the same edge as a clear of bit 3: set wins
    btn = 5'b01000;
    for (int k = 0; k < 5; k++) step();
    read_check("collide_pre", AddrEvents, 32'h0);
    write(AddrEvents, 32'h8);
    read_check("collide_events", AddrEvents, 32'h8);
    read_check("collide_level", AddrLevel, 32'h8);
    write(AddrEvents, 32'h0);
    read_check("w0_no_change", AddrEvents, 32'h8);
    write(AddrEvents, 32'h8);
    read_check("w1c_bit3", AddrEvents, 32'h0);

    // Reset mid-debounce on button 4 with cnt[4]=2
    btn = 5'b10000;
    for (int k = 0; k < 4; k++) step();
    check("mid_cnt4", 32'(dut.cnt_q[4]), 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    read_check("rst2_level", AddrLevel, 32'h0);
    read_check("rst2_events", AddrEvents, 32'h0);
    check("rst2_cnt4", 32'(dut.cnt_q[4]), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      read_check($sformatf("held_level_e%0d", k), AddrLevel, 32'h0);
    end
    step();
    read_check("held_level_e6", AddrLevel, 32'h10);
    read_check("held_events", AddrEvents, 32'h10);

    // Write to LEVEL is ignored
    write(AddrLevel, 32'hFFFF_FFFF);
    read_check("level_wr_level", AddrLevel, 32'h10);
    read_check("level_wr_events", AddrEvents, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
